// File: rtl/yuv420_unpack.sv
// yuv420_unpack
//   Expands the packed 32-bit YUV420 word stream back into one pixel per
//   cycle. Even-row words {V,Y1,U,Y0} yield two pixels and store their
//   chroma pair in a line buffer. Odd-row words {Y3,Y2,Y1,Y0} yield four
//   pixels that take their chroma from that buffer. Marker words pass
//   through with zero pixel data.
//
//   Ports:
//     clk, reset        image clock, synchronous active-high reset
//     dvi, dtypei,      input word valid, data type, packed word
//     datai
//     rdyo              word accepted when dvi && rdyo
//     dvo, dtypeo       output pixel/marker valid, data type
//     yo, uo, vo        pixel components, MSB-aligned into PIXEL_WIDTH
//
//   Build option: YUV420_UNPACK_UV_OFFSET_EN inverts the chroma MSB on
//   output (offset-binary to two's complement). Luma is unaffected.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h01
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h02
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h03
`endif

module yuv420_unpack #(
    parameter int                      PIXEL_WIDTH       = 8,
    parameter int                      MAX_COLS          = 1920,
    parameter logic [`DTYPE_WIDTH-1:0] DTYPE_PIXEL       = `DTYPE_PIXEL,
    parameter logic [`DTYPE_WIDTH-1:0] DTYPE_ROW_END     = `DTYPE_ROW_END,
    parameter logic [`DTYPE_WIDTH-1:0] DTYPE_FRAME_START = `DTYPE_FRAME_START
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dvi,
    output logic                    rdyo,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [31:0]             datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [PIXEL_WIDTH-1:0]  yo,
    output logic [PIXEL_WIDTH-1:0]  uo,
    output logic [PIXEL_WIDTH-1:0]  vo
);

    localparam int HALF = MAX_COLS / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW   = $clog2(HALF + 4) + 1;
    localparam logic [PIXEL_WIDTH-1:0] UV_MSB = PIXEL_WIDTH'(1) << (PIXEL_WIDTH - 1);

    typedef enum logic [1:0] {K_EVEN, K_ODD, K_MARK} kind_t;
    typedef enum logic [1:0] {SRC_DIRECT, SRC_BUF, SRC_FILL} src_t;

    function automatic logic [PIXEL_WIDTH-1:0] widen(input logic [7:0] b);
        logic [PIXEL_WIDTH+7:0] t;
        t = '0;
        t[PIXEL_WIDTH+7 -: 8] = b;
        return t[PIXEL_WIDTH+7:8];
    endfunction

    // holding register and row state
    logic                    rdy_en;
    logic [2:0]              cnt;
    logic [1:0]              idx;
    logic [31:0]             h_word;
    logic [`DTYPE_WIDTH-1:0] h_dtype;
    kind_t                   h_kind;
    logic [CW-1:0]           h_col;
    logic                    parity;     // 0 = even row
    logic [CW-1:0]           col;        // saturates at HALF
    logic [CW-1:0]           saved;      // pairs written by the last even row

    // buffer read stage
    logic                    s1_valid;
    logic                    s1_pix;
    logic [`DTYPE_WIDTH-1:0] s1_dtype;
    logic [7:0]              s1_y, s1_u, s1_v;
    src_t                    s1_src;
    logic [15:0]             rd_q;
    logic [15:0]             lbuf [HALF];

    logic                    accept, issue, wr_en;
    logic [7:0]              iss_y, iss_u, iss_v;
    src_t                    iss_src;
    logic [CW-1:0]           rd_entry;
    logic [7:0]              out_u, out_v;

    // Accept only when the word in hand is on its last element, so the
    // next word lands exactly as the previous one finishes issuing.
    assign rdyo   = rdy_en && (cnt <= 3'd1);
    assign accept = dvi && rdyo;
    assign issue  = (cnt != 3'd0);
    assign wr_en  = accept && !reset && (dtypei == DTYPE_PIXEL) && !parity
                    && (col < CW'(HALF));

    always_comb begin
        iss_y    = '0;
        iss_u    = '0;
        iss_v    = '0;
        iss_src  = SRC_DIRECT;
        rd_entry = '0;
        case (h_kind)
            K_EVEN: begin
                iss_y = idx[0] ? h_word[23:16] : h_word[7:0];
                iss_u = h_word[15:8];
                iss_v = h_word[31:24];
            end
            K_ODD: begin
                iss_y    = h_word[{idx, 3'b000} +: 8];
                rd_entry = h_col + CW'(idx[1]);
                iss_src  = (rd_entry < saved) ? SRC_BUF : SRC_FILL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            lbuf[col[AW-1:0]] <= {datai[15:8], datai[31:24]};
        rd_q <= lbuf[rd_entry[AW-1:0]];
    end

    always_comb begin
        out_u = s1_u;
        out_v = s1_v;
        case (s1_src)
            SRC_BUF:  begin out_u = rd_q[15:8]; out_v = rd_q[7:0]; end
            SRC_FILL: begin out_u = 8'h80;      out_v = 8'h80;     end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_en   <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            h_word   <= '0;
            h_dtype  <= '0;
            h_kind   <= K_MARK;
            h_col    <= '0;
            parity   <= 1'b0;
            col      <= '0;
            saved    <= '0;
            s1_valid <= 1'b0;
            s1_pix   <= 1'b0;
            s1_dtype <= '0;
            s1_y     <= '0;
            s1_u     <= '0;
            s1_v     <= '0;
            s1_src   <= SRC_DIRECT;
            dvo      <= 1'b0;
            dtypeo   <= '0;
            yo       <= '0;
            uo       <= '0;
            vo       <= '0;
        end else begin
            rdy_en   <= 1'b1;
            s1_valid <= issue;
            if (issue) begin
                s1_pix   <= (h_kind != K_MARK);
                s1_dtype <= h_dtype;
                s1_y     <= iss_y;
                s1_u     <= iss_u;
                s1_v     <= iss_v;
                s1_src   <= iss_src;
                idx      <= idx + 2'd1;
            end

            if (accept) begin
                h_word  <= datai;
                h_dtype <= dtypei;
                h_col   <= col;
                idx     <= '0;
                if (dtypei == DTYPE_PIXEL) begin
                    if (!parity) begin
                        h_kind <= K_EVEN;
                        cnt    <= 3'd2;
                        if (col < CW'(HALF)) col <= col + CW'(1);
                    end else begin
                        h_kind <= K_ODD;
                        cnt    <= 3'd4;
                        if (col < CW'(HALF)) col <= col + CW'(2);
                    end
                end else begin
                    h_kind <= K_MARK;
                    cnt    <= 3'd1;
                    if (dtypei == DTYPE_ROW_END) begin
                        if (!parity) saved <= col;
                        parity <= ~parity;
                        col    <= '0;
                    end else if (dtypei == DTYPE_FRAME_START) begin
                        parity <= 1'b0;
                        col    <= '0;
                        saved  <= '0;
                    end
                end
            end else if (issue) begin
                cnt <= cnt - 3'd1;
            end

            dvo    <= s1_valid;
            dtypeo <= s1_valid ? s1_dtype : '0;
            yo     <= (s1_valid && s1_pix) ? widen(s1_y) : '0;
`ifdef YUV420_UNPACK_UV_OFFSET_EN
            uo     <= (s1_valid && s1_pix) ? (widen(out_u) ^ UV_MSB) : '0;
            vo     <= (s1_valid && s1_pix) ? (widen(out_v) ^ UV_MSB) : '0;
`else
            uo     <= (s1_valid && s1_pix) ? widen(out_u) : '0;
            vo     <= (s1_valid && s1_pix) ? widen(out_v) : '0;
`endif
        end
    end

endmodule

// File: tb/tb_yuv420_unpack.sv
// tb_yuv420_unpack
//   Directed bench for yuv420_unpack (MAX_COLS = 16, 8 chroma pairs).
//   Expected pixels are pushed into a queue in output order; a monitor
//   compares every valid output against it.

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 8'h01
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h02
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h03
`endif

module tb_yuv420_unpack;

    localparam int DW = `DTYPE_WIDTH;
    localparam logic [DW-1:0] DT_PIX = `DTYPE_PIXEL;
    localparam logic [DW-1:0] DT_RE  = `DTYPE_ROW_END;
    localparam logic [DW-1:0] DT_FS  = `DTYPE_FRAME_START;

    logic          clk = 1'b0;
    logic          reset;
    logic          dvi;
    logic          rdyo;
    logic [DW-1:0] dtypei;
    logic [31:0]   datai;
    logic          dvo;
    logic [DW-1:0] dtypeo;
    logic [7:0]    yo, uo, vo;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned run      = 0;
    int unsigned max_run  = 0;
    logic [DW+23:0] exp_q [$];

    always #5 clk = ~clk;

    yuv420_unpack #(
        .PIXEL_WIDTH (8),
        .MAX_COLS    (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dvi    (dvi),
        .rdyo   (rdyo),
        .dtypei (dtypei),
        .datai  (datai),
        .dvo    (dvo),
        .dtypeo (dtypeo),
        .yo     (yo),
        .uo     (uo),
        .vo     (vo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void push_pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
        logic [7:0] uu, vv;
        uu = u;
        vv = v;
`ifdef YUV420_UNPACK_UV_OFFSET_EN
        uu = uu ^ 8'h80;
        vv = vv ^ 8'h80;
`endif
        exp_q.push_back({DT_PIX, y, uu, vv});
    endfunction

    function automatic void push_mark(input logic [DW-1:0] dt);
        exp_q.push_back({dt, 24'h0});
    endfunction

    task automatic idle(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called 1 ns after an edge; returns 1 ns after the accepting edge.
    task automatic send(input logic [DW-1:0] dt, input logic [31:0] w);
        int unsigned n;
        n = 0;
        dvi = 1'b1;
        dtypei = dt;
        datai = w;
        while (!rdyo && n < 50) begin @(posedge clk); #1; n++; end
        if (!rdyo) check("send_timeout", rdyo, 1);
        @(posedge clk); #1;
        dvi = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (dvo) begin
            if (exp_q.size() == 0) check("unexpected_dvo", dvo, 0);
            else check("pixel", {dtypeo, yo, uo, vo}, exp_q.pop_front());
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (reset) exp_q.delete();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b0, b1, b2, b3, u, v;
        int unsigned sent;
        reset = 1'b1;
        dvi = 1'b0;
        dtypei = '0;
        datai = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dvo", dvo, 0);
        check("rst_rdyo", rdyo, 0);
        check("rst_outs", {dtypeo, yo, uo, vo}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rdyo_after_reset", rdyo, 1);
        check("idle_dvo", dvo, 0);

        // frame start, one even word, latency of two edges
        push_mark(DT_FS);
        send(DT_FS, 32'h0);
        idle(4);
        push_pix(8'h10, 8'h20, 8'h40);
        push_pix(8'h30, 8'h20, 8'h40);
        send(DT_PIX, 32'h40302010);
        check("lat_edge0", dvo, 0);
        @(posedge clk); #1;
        check("lat_edge1", dvo, 0);
        @(posedge clk); #1;
        check("lat_edge2", dvo, 1);
        check("lat_y0", yo, 8'h10);
        idle(4);

        // even row of 4 words, odd row of 2 words
        push_mark(DT_FS);
        send(DT_FS, 32'h0);
        for (int i = 0; i < 4; i++) begin
            b0 = 8'(8'h20 + 2 * i);
            b1 = 8'(8'h21 + 2 * i);
            u  = 8'(8'h50 + i);
            v  = 8'(8'h60 + i);
            push_pix(b0, u, v);
            push_pix(b1, u, v);
            send(DT_PIX, {v, b1, u, b0});
        end
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        push_pix(8'h0A, 8'h50, 8'h60); push_pix(8'h0B, 8'h50, 8'h60);
        push_pix(8'h0C, 8'h51, 8'h61); push_pix(8'h0D, 8'h51, 8'h61);
        push_pix(8'h0E, 8'h52, 8'h62); push_pix(8'h0F, 8'h52, 8'h62);
        push_pix(8'h10, 8'h53, 8'h63); push_pix(8'h11, 8'h53, 8'h63);
        send(DT_PIX, 32'h0D0C0B0A);
        send(DT_PIX, 32'h11100F0E);
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        idle(8);

        // odd row longer than the 3-pair even row before it
        push_mark(DT_FS);
        send(DT_FS, 32'h0);
        for (int i = 0; i < 3; i++) begin
            b0 = 8'(8'h40 + 2 * i);
            b1 = 8'(8'h41 + 2 * i);
            u  = 8'(8'h70 + i);
            v  = 8'(8'h90 + i);
            push_pix(b0, u, v);
            push_pix(b1, u, v);
            send(DT_PIX, {v, b1, u, b0});
        end
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        push_pix(8'h00, 8'h70, 8'h90); push_pix(8'h01, 8'h70, 8'h90);
        push_pix(8'h02, 8'h71, 8'h91); push_pix(8'h03, 8'h71, 8'h91);
        push_pix(8'h04, 8'h72, 8'h92); push_pix(8'h05, 8'h72, 8'h92);
        push_pix(8'h06, 8'h80, 8'h80); push_pix(8'h07, 8'h80, 8'h80);
        send(DT_PIX, 32'h03020100);
        send(DT_PIX, 32'h07060504);
        push_mark(DT_RE);
        send(DT_RE, 32'h0);

        // rows of MAX_COLS+8 pixels: writes past 8 pairs suppressed
        for (int i = 0; i < 12; i++) begin
            b0 = 8'(2 * i);
            b1 = 8'(2 * i + 1);
            u  = 8'(8'hA0 + i);
            v  = 8'(8'hB0 + i);
            push_pix(b0, u, v);
            push_pix(b1, u, v);
            send(DT_PIX, {v, b1, u, b0});
        end
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 4; k++) begin
                int pair;
                pair = 2 * j + k / 2;
                if (pair < 8) push_pix(8'(4 * j + k), 8'(8'hA0 + pair), 8'(8'hB0 + pair));
                else          push_pix(8'(4 * j + k), 8'h80, 8'h80);
            end
            b0 = 8'(4 * j);
            b1 = 8'(4 * j + 1);
            b2 = 8'(4 * j + 2);
            b3 = 8'(4 * j + 3);
            send(DT_PIX, {b3, b2, b1, b0});
        end
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        idle(8);

        // back-to-back odd words after an empty even row: all fill chroma
        push_mark(DT_FS);
        send(DT_FS, 32'h0);
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        idle(6);
        max_run = 0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 4; k++)
                push_pix(8'(4 * j + k), 8'h80, 8'h80);
        sent = 0;
        dvi = 1'b1;
        dtypei = DT_PIX;
        for (int c = 0; c < 100 && sent < 16; c++) begin
            b0 = 8'(4 * sent);
            b1 = 8'(4 * sent + 1);
            b2 = 8'(4 * sent + 2);
            b3 = 8'(4 * sent + 3);
            datai = {b3, b2, b1, b0};
            check("rdyo_pattern", rdyo, (c % 4) == 0);
            if (rdyo) sent++;
            @(posedge clk); #1;
        end
        dvi = 1'b0;
        check("b2b_words_sent", sent, 16);
        idle(8);
        check("b2b_dvo_run", max_run, 64);

        // reset between Y1 and Y2 of an odd word
        push_mark(DT_FS);
        send(DT_FS, 32'h0);
        push_mark(DT_RE);
        send(DT_RE, 32'h0);
        push_pix(8'h0A, 8'h80, 8'h80); push_pix(8'h0B, 8'h80, 8'h80);
        push_pix(8'h0C, 8'h80, 8'h80); push_pix(8'h0D, 8'h80, 8'h80);
        send(DT_PIX, 32'h0D0C0B0A);
        idle(3);
        check("pre_reset_y1", {dvo, yo}, {1'b1, 8'h0B});
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_dvo", dvo, 0);
        check("mid_reset_outs", {dtypeo, yo, uo, vo}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_reset_rdyo", rdyo, 1);
        push_pix(8'h11, 8'h22, 8'h44);
        push_pix(8'h33, 8'h22, 8'h44);
        send(DT_PIX, 32'h44332211);
        idle(6);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
